// File: rtl/pattern_gen.sv
// Serialises a latched frame of Bike/Car symbols, adds a programmable idle gap,
// and counts BCCCB occurrences in the emitted symbol stream.
module pattern_gen #(
   parameter logic B       = 1'b0,
   parameter logic C       = 1'b1,
   parameter int   FRAME_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic [3:0]         frame_len,
   input  logic [3:0]         gap_in,
   output logic               ready,
   output logic               d_out,
   output logic               valid_out,
   output logic               done,
   output logic [7:0]         pat_count
);

   localparam int IW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
   typedef enum logic [2:0] {T_RST, T_B, T_BC, T_BCC, T_BCCC} trk_e;

   state_e             state_q, state_d;
   trk_e               trk_q, trk_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [3:0]         len_q, len_d;
   logic [3:0]         gap_q, gap_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [3:0]         cnt_inc;
   logic [3:0]         eff_len;
   logic               ready_q, ready_d;
   logic               d_out_q, d_out_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic [7:0]         pat_q, pat_d;

   assign cnt_inc = cnt_q + 4'd1;

   always_comb begin
      eff_len = frame_len;
      if (frame_len == 4'd0 || frame_len > 4'(FRAME_W))
         eff_len = 4'(FRAME_W);
   end

   // Output registers are loaded from next-state values so every port is a flop
   // that already shows the symbol or status of the coming cycle.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      frame_d = frame_q;
      len_d   = len_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      ready_d = 1'b0;
      d_out_d = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (start) begin
               frame_d = frame_in;
               len_d   = eff_len;
               gap_d   = gap_in;
               cnt_d   = 4'd0;
               state_d = SEND;
               ready_d = 1'b0;
               valid_d = 1'b1;
               d_out_d = frame_in[0];
            end
         end
         SEND: begin
            if (cnt_q == len_q - 4'd1) begin
               cnt_d = 4'd0;
               if (gap_q != 4'd0) begin
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d   = cnt_inc;
               valid_d = 1'b1;
               d_out_d = frame_q[cnt_inc[IW-1:0]];
            end
         end
         GAP: begin
            if (cnt_q == gap_q - 4'd1) begin
               state_d = IDLE;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // Tracker watches the symbols actually on the outputs, so it naturally spans frames.
   always_comb begin
      trk_d = trk_q;
      pat_d = pat_q;
      if (!(trk_q inside {T_RST, T_B, T_BC, T_BCC, T_BCCC})) begin
         trk_d = T_RST;
      end else if (valid_q) begin
         if (d_out_q == B) begin
            trk_d = T_B;
            if (trk_q == T_BCCC && pat_q != 8'hFF)
               pat_d = pat_q + 8'd1;
         end else begin
            case (trk_q)
               T_B:     trk_d = T_BC;
               T_BC:    trk_d = T_BCC;
               T_BCC:   trk_d = T_BCCC;
               default: trk_d = T_RST;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q <= IDLE;
         trk_q   <= T_RST;
         frame_q <= '0;
         len_q   <= '0;
         gap_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         d_out_q <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         trk_q   <= trk_d;
         frame_q <= frame_d;
         len_q   <= len_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         d_out_q <= d_out_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         pat_q   <= pat_d;
      end
   end

   assign ready     = ready_q;
   assign d_out     = d_out_q;
   assign valid_out = valid_q;
   assign done      = done_q;
   assign pat_count = pat_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: framing, gap, length clamp, busy start,
// mid-frame reset and cross-frame BCCCB counting.
module tb_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] frame_in;
   logic [3:0] frame_len;
   logic [3:0] gap_in;
   logic       ready;
   logic       d_out;
   logic       valid_out;
   logic       done;
   logic [7:0] pat_count;

   int n_checks = 0;
   int n_pass   = 0;

   pattern_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_in  (frame_in),
      .frame_len (frame_len),
      .gap_in    (gap_in),
      .ready     (ready),
      .d_out     (d_out),
      .valid_out (valid_out),
      .done      (done),
      .pat_count (pat_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Called in a ready cycle t; returns in cycle t+1 with start released.
   task automatic start_frame(input logic [7:0] f, input logic [3:0] len, input logic [3:0] gap);
      frame_in  = f;
      frame_len = len;
      gap_in    = gap;
      start     = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Checks symbols at t+1..t+n; returns in cycle t+n.
   task automatic expect_syms(input string tag, input logic [7:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, 8'(valid_out), 8'd1);
         check({tag, "_dout"},  8'(d_out),     8'(bits[i]));
         check({tag, "_ready"}, 8'(ready),     8'd0);
         check({tag, "_done"},  8'(done),      8'd0);
         if (i < n - 1) step();
      end
   endtask

   initial begin
      // Reset held two cycles with start asserted
      rst = 1'b1; start = 1'b1; frame_in = 8'hFF; frame_len = 4'd5; gap_in = 4'd0;
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_ready", 8'(ready),     8'd1);
         check("rst_valid", 8'(valid_out), 8'd0);
         check("rst_done",  8'(done),      8'd0);
         check("rst_pat",   pat_count,     8'd0);
      end
      rst = 1'b0; start = 1'b0;
      step();
      check("post_rst_ready", 8'(ready),     8'd1);
      check("post_rst_valid", 8'(valid_out), 8'd0);
      check("post_rst_dout",  8'(d_out),     8'd0);

      // Single BCCCB pattern
      start_frame(8'h0E, 4'd5, 4'd0);
      expect_syms("single", 8'h0E, 5);
      check("single_pat_last", pat_count, 8'd0);
      step();
      check("single_done",  8'(done),      8'd1);
      check("single_ready", 8'(ready),     8'd1);
      check("single_valid", 8'(valid_out), 8'd0);
      check("single_dout",  8'(d_out),     8'd0);
      check("single_pat",   pat_count,     8'd1);
      step();
      check("single_done_pulse", 8'(done), 8'd0);
      check("single_pat_hold",   pat_count, 8'd1);

      // Cross-frame overlap, second frame started in the done cycle
      do_reset();
      start_frame(8'hEE, 4'd8, 4'd0);
      expect_syms("xf1", 8'hEE, 8);
      step();
      check("xf1_done",  8'(done),      8'd1);
      check("xf1_valid", 8'(valid_out), 8'd0);
      check("xf1_pat",   pat_count,     8'd1);
      start_frame(8'h00, 4'd1, 4'd0);
      expect_syms("xf2", 8'h00, 1);
      check("xf2_pat_pre", pat_count, 8'd1);
      step();
      check("xf2_done", 8'(done),  8'd1);
      check("xf2_pat",  pat_count, 8'd2);

      // Length 0 means 8, with a 3-cycle gap
      step();
      start_frame(8'hA5, 4'd0, 4'd3);
      expect_syms("gap", 8'hA5, 8);
      for (int i = 0; i < 3; i++) begin
         step();
         check("gap_valid", 8'(valid_out), 8'd0);
         check("gap_dout",  8'(d_out),     8'd0);
         check("gap_ready", 8'(ready),     8'd0);
         check("gap_done",  8'(done),      8'd0);
      end
      step();
      check("gap_end_done",  8'(done),  8'd1);
      check("gap_end_ready", 8'(ready), 8'd1);

      // Length 12 clamps to 8
      step();
      start_frame(8'h5A, 4'd12, 4'd0);
      expect_syms("clamp", 8'h5A, 8);
      step();
      check("clamp_valid", 8'(valid_out), 8'd0);
      check("clamp_done",  8'(done),      8'd1);

      // Start while busy is ignored
      do_reset();
      start_frame(8'h0E, 4'd5, 4'd0);
      expect_syms("busy_a", 8'h0E, 1);
      step();
      check("busy_s1", 8'(d_out), 8'd1);
      frame_in = 8'hF1; frame_len = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      check("busy_s2",    8'(d_out),     8'd1);
      check("busy_s2_v",  8'(valid_out), 8'd1);
      step();
      check("busy_s3", 8'(d_out), 8'd1);
      step();
      check("busy_s4",   8'(d_out),     8'd0);
      check("busy_s4_v", 8'(valid_out), 8'd1);
      step();
      check("busy_done", 8'(done),  8'd1);
      check("busy_pat",  pat_count, 8'd1);
      step();
      check("busy_single_done", 8'(done),      8'd0);
      check("busy_no_restart",  8'(valid_out), 8'd0);

      // Reset in the middle of SEND
      do_reset();
      start_frame(8'h0E, 4'd5, 4'd0);
      expect_syms("mid", 8'h0E, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_valid", 8'(valid_out), 8'd0);
      check("mid_ready", 8'(ready),     8'd1);
      check("mid_pat",   pat_count,     8'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("mid_no_done",  8'(done),      8'd0);
         check("mid_no_valid", 8'(valid_out), 8'd0);
      end
      start_frame(8'h0E, 4'd5, 4'd0);
      expect_syms("mid_next", 8'h0E, 5);
      step();
      check("mid_next_done", 8'(done),  8'd1);
      check("mid_next_pat",  pat_count, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
